// File: rtl/noisy_signal_gen.sv
// -----------------------------------------------------------------------------
// noisy_signal_gen
//
// Synthetic ADC-like test source for the coherent-average / lock-in bench.
// Emits a square wave of programmable amplitude (N_SAMPLES samples per period,
// one sample every CLK_DIV clocks) with pseudo-random noise added. The noise
// word comes from an external generator. This block pulses that generator's
// enable exactly once per emitted sample.
//
// Build option:
//   NOISY_SIG_SATURATE_EN  defined   -> sum clamped to the signed output range
//                          undefined -> sum wraps (low DATA_WIDTH bits kept)
//
// Parameter constraints: N_SAMPLES even and >= 2, CLK_DIV >= 2,
// NOISE_BITS < DATA_WIDTH.
//
// Ports:
//   i_Clk           clock
//   i_Reset         synchronous, active-high reset (priority over everything)
//   i_Enable        level run request; stops are always period-aligned
//   i_Amplitude     unsigned amplitude, clamped to 2^(DATA_WIDTH-1)-1
//   i_Noise_Shift   arithmetic right shift of the noise word (>= NOISE_BITS -> 0)
//   i_LFSR_Data     current noise word, two's complement
//   o_LFSR_Enable   high during the tick cycle; the generator advances after use
//   o_Data          signed sample, held between strobes
//   o_Data_Valid    one-cycle strobe for o_Data
//   o_Period_Start  high with the strobe of sample index 0
//   o_Frame_Count   completed periods since the last start, saturating
//   o_Busy          high in RUN and DRAIN
//   o_State         debug view of the FSM state (0 IDLE, 1 RUN, 2 DRAIN)
//
// Output protocol: o_Data_Valid is a pure strobe with no ready/backpressure.
// o_Data is valid in exactly the cycle o_Data_Valid is high; the consumer must
// take it in that cycle. o_Period_Start is only meaningful with o_Data_Valid.
// -----------------------------------------------------------------------------
module noisy_signal_gen #(
    parameter int DATA_WIDTH = 14,
    parameter int NOISE_BITS = 12,
    parameter int N_SAMPLES  = 32,
    parameter int CLK_DIV    = 4
) (
    input  logic                         i_Clk,
    input  logic                         i_Reset,
    input  logic                         i_Enable,
    input  logic [DATA_WIDTH-1:0]        i_Amplitude,
    input  logic [3:0]                   i_Noise_Shift,
    input  logic [NOISE_BITS-1:0]        i_LFSR_Data,
    output logic                         o_LFSR_Enable,
    output logic signed [DATA_WIDTH-1:0] o_Data,
    output logic                         o_Data_Valid,
    output logic                         o_Period_Start,
    output logic [15:0]                  o_Frame_Count,
    output logic                         o_Busy,
    output logic [1:0]                   o_State
);

    localparam int IDX_W = (N_SAMPLES > 2) ? $clog2(N_SAMPLES) : 1;
    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(N_SAMPLES - 1);
    localparam logic [IDX_W-1:0]      IDX_HALF = IDX_W'(N_SAMPLES / 2);
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DATA_WIDTH-1:0] AMP_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};

`ifdef NOISY_SIG_SATURATE_EN
    // Two guard bits: |sig| <= 2^(DW-1)-1 and |noise| < 2^(DW-1) never overflow.
    localparam int SUM_W = DATA_WIDTH + 2;
    localparam logic signed [SUM_W-1:0] SUM_MAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SUM_MIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};
`else
    // Wrapping keeps only the low DATA_WIDTH bits of the wide sum, and modular
    // addition gives the same low bits when the adder itself is that narrow.
    localparam int SUM_W = DATA_WIDTH;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_next;
    logic [DIV_W-1:0]        div_q, div_next;
    logic [IDX_W-1:0]        idx_q, idx_next;
    logic [15:0]             frame_q, frame_next;
    logic [DATA_WIDTH-1:0]   data_q, data_next;
    logic                    valid_q, valid_next;
    logic                    pstart_q, pstart_next;
    logic                    lfsr_en_q, lfsr_en_next;

    // ---------------- sample datapath (uses the current index) ----------------
    logic [DATA_WIDTH-1:0]        amp_c;
    logic signed [NOISE_BITS-1:0] lfsr_s;
    logic signed [NOISE_BITS-1:0] noise_sh;
    logic signed [SUM_W-1:0]      amp_ext;
    logic signed [SUM_W-1:0]      sig;
    logic signed [SUM_W-1:0]      noise_ext;
    logic signed [SUM_W-1:0]      sum;
    logic [DATA_WIDTH-1:0]        sample;

    always_comb begin
        amp_c = (i_Amplitude > AMP_MAX) ? AMP_MAX : i_Amplitude;
        lfsr_s = i_LFSR_Data;
        // A plain >>> would leave -1 for negative words at large shifts; the
        // intent is that a large shift removes the noise entirely.
        if (32'(i_Noise_Shift) >= 32'(NOISE_BITS)) begin
            noise_sh = '0;
        end else begin
            noise_sh = lfsr_s >>> i_Noise_Shift;
        end
        noise_ext = {{(SUM_W-NOISE_BITS){noise_sh[NOISE_BITS-1]}}, noise_sh};
        amp_ext   = SUM_W'(amp_c);
        sig       = (idx_q < IDX_HALF) ? amp_ext : -amp_ext;
        sum       = sig + noise_ext;
`ifdef NOISY_SIG_SATURATE_EN
        if (sum > SUM_MAX) begin
            sample = SUM_MAX[DATA_WIDTH-1:0];
        end else if (sum < SUM_MIN) begin
            sample = SUM_MIN[DATA_WIDTH-1:0];
        end else begin
            sample = sum[DATA_WIDTH-1:0];
        end
`else
        sample = sum[DATA_WIDTH-1:0];
`endif
    end

    // ---------------- FSM next-state / next-output ----------------
    always_comb begin
        state_next  = state_q;
        div_next    = div_q;
        idx_next    = idx_q;
        frame_next  = frame_q;
        data_next   = data_q;
        valid_next  = 1'b0;
        pstart_next = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_Enable) begin
                    state_next = ST_RUN;
                    div_next   = '0;
                    idx_next   = '0;
                    frame_next = '0;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (div_q == DIV_LAST) begin
                    // Tick: emit the sample for idx_q and move to the next index.
                    div_next    = '0;
                    idx_next    = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    data_next   = sample;
                    valid_next  = 1'b1;
                    pstart_next = (idx_q == '0);
                    if (idx_q == IDX_LAST && frame_q != 16'hFFFF) begin
                        frame_next = frame_q + 16'd1;
                    end
                    // Stop decisions happen only here, so every stop lands on a
                    // period boundary.
                    if (idx_q == IDX_LAST) begin
                        if (state_q == ST_DRAIN || !i_Enable) begin
                            state_next = ST_IDLE;
                        end
                    end else if (state_q == ST_RUN && !i_Enable) begin
                        state_next = ST_DRAIN;
                    end
                end else begin
                    div_next = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Registered so that it is high in the cycle whose divider is at its
        // last value, i.e. the same cycle the noise word is sampled.
        lfsr_en_next = (state_next != ST_IDLE) && (div_next == DIV_LAST);
    end

    // ---------------- state register ----------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            pstart_q  <= 1'b0;
            lfsr_en_q <= 1'b0;
        end else begin
            state_q   <= state_next;
            div_q     <= div_next;
            idx_q     <= idx_next;
            frame_q   <= frame_next;
            data_q    <= data_next;
            valid_q   <= valid_next;
            pstart_q  <= pstart_next;
            lfsr_en_q <= lfsr_en_next;
        end
    end

    assign o_LFSR_Enable  = lfsr_en_q;
    assign o_Data         = data_q;
    assign o_Data_Valid   = valid_q;
    assign o_Period_Start = pstart_q;
    assign o_Frame_Count  = frame_q;
    assign o_Busy         = (state_q != ST_IDLE);
    assign o_State        = state_q;

endmodule

// File: tb/tb_noisy_signal_gen.sv
// -----------------------------------------------------------------------------
// tb_noisy_signal_gen
//
// Bench for noisy_signal_gen with default parameters. A stand-in noise
// generator hands out a new random word each time the DUT pulses
// o_LFSR_Enable. Expected samples come from an arithmetic model of the
// waveform + noise + reduction rules and are queued in exp_q, one entry per
// upcoming strobe.
// -----------------------------------------------------------------------------
module tb_noisy_signal_gen;

    localparam int DW   = 14;
    localparam int NB   = 12;
    localparam int NS   = 32;
    localparam int CD   = 4;
    localparam int MAXV = (1 << (DW - 1)) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic                 i_Clk = 1'b0;
    logic                 i_Reset;
    logic                 i_Enable;
    logic [DW-1:0]        i_Amplitude;
    logic [3:0]           i_Noise_Shift;
    logic [NB-1:0]        i_LFSR_Data;
    logic                 o_LFSR_Enable;
    logic signed [DW-1:0] o_Data;
    logic                 o_Data_Valid;
    logic                 o_Period_Start;
    logic [15:0]          o_Frame_Count;
    logic                 o_Busy;
    logic [1:0]           o_State;

    always #5 i_Clk = ~i_Clk;

    noisy_signal_gen #(
        .DATA_WIDTH (DW),
        .NOISE_BITS (NB),
        .N_SAMPLES  (NS),
        .CLK_DIV    (CD)
    ) dut (
        .i_Clk          (i_Clk),
        .i_Reset        (i_Reset),
        .i_Enable       (i_Enable),
        .i_Amplitude    (i_Amplitude),
        .i_Noise_Shift  (i_Noise_Shift),
        .i_LFSR_Data    (i_LFSR_Data),
        .o_LFSR_Enable  (o_LFSR_Enable),
        .o_Data         (o_Data),
        .o_Data_Valid   (o_Data_Valid),
        .o_Period_Start (o_Period_Start),
        .o_Frame_Count  (o_Frame_Count),
        .o_Busy         (o_Busy),
        .o_State        (o_State)
    );

    // ---------------- bookkeeping ----------------
    int            tests_run    = 0;
    int            tests_failed = 0;
    int            lfsr_cnt     = 0;
    int            strobe_cnt   = 0;
    bit            gen_on       = 1'b0;
    logic [DW-1:0] exp_q[$];

    // Values sampled at the falling edge by cycle().
    logic          s_valid, s_pstart, s_lfsr, s_busy;
    logic [DW-1:0] s_dbits;
    logic [15:0]   s_frame;
    logic [1:0]    s_state;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic int model(int amp, int shift, logic [NB-1:0] w, int idx);
        int a, n, s;
        a = (amp > MAXV) ? MAXV : amp;
        n = int'(w);
        if (n >= (1 << (NB - 1))) n = n - (1 << NB);
        n = (shift >= NB) ? 0 : (n >>> shift);
        s = ((idx < NS / 2) ? a : -a) + n;
`ifdef NOISY_SIG_SATURATE_EN
        if (s > MAXV) s = MAXV;
        if (s < -MAXV - 1) s = -MAXV - 1;
`else
        s = s & ((1 << DW) - 1);
        if (s > MAXV) s = s - (1 << DW);
`endif
        return s;
    endfunction

    // ---------------- driver tasks ----------------
    // One clock: sample outputs at the falling edge, then return just after the
    // rising edge. The stand-in generator advances after a cycle in which the
    // DUT requested it.
    task automatic cycle();
        @(negedge i_Clk);
        s_valid  = o_Data_Valid;
        s_pstart = o_Period_Start;
        s_lfsr   = o_LFSR_Enable;
        s_busy   = o_Busy;
        s_dbits  = o_Data;
        s_frame  = o_Frame_Count;
        s_state  = o_State;
        if (s_lfsr)  lfsr_cnt++;
        if (s_valid) strobe_cnt++;
        @(posedge i_Clk);
        #1;
        if (s_lfsr && gen_on) i_LFSR_Data = NB'($urandom);
    endtask

    // Queue the expected value of the sample at index idx using the inputs the
    // DUT will see at its next tick.
    task automatic push_exp(input int idx);
        exp_q.push_back(DW'(model(int'(i_Amplitude), int'(i_Noise_Shift), i_LFSR_Data, idx)));
    endtask

    task automatic randomize_inputs();
        i_Amplitude   = DW'($urandom_range(0, (1 << DW) - 1));
        i_Noise_Shift = 4'($urandom_range(0, 15));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_Reset = 1'b1;
        repeat (3) cycle();
        tests_run++; if (s_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b expected 0", s_valid); end
        tests_run++; if (s_pstart !== 1'b0) begin tests_failed++; $display("FAIL reset_pstart: got %0b expected 0", s_pstart); end
        tests_run++; if (s_lfsr !== 1'b0) begin tests_failed++; $display("FAIL reset_lfsr: got %0b expected 0", s_lfsr); end
        tests_run++; if (s_dbits !== '0) begin tests_failed++; $display("FAIL reset_data: got %0d expected 0", $signed(s_dbits)); end
        tests_run++; if (s_frame !== 16'd0) begin tests_failed++; $display("FAIL reset_frame: got %0d expected 0", s_frame); end
        tests_run++; if (s_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b expected 0", s_busy); end
        tests_run++; if (s_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", s_state); end
        i_Reset = 1'b0;
        repeat (3) cycle();
        tests_run++; if (s_busy !== 1'b0 || s_lfsr !== 1'b0) begin tests_failed++; $display("FAIL idle_hold: got busy=%0b lfsr=%0b expected 0/0", s_busy, s_lfsr); end
    endtask

    task automatic test_clean_wave();
        int k = 0, t_last = 0, extra = 0;
        logic [DW-1:0] e;
        i_Amplitude = DW'(1000); i_LFSR_Data = '0; i_Noise_Shift = 4'd0; gen_on = 1'b0;
        i_Enable = 1'b1;
        for (int c = 1; c <= 400 && k < 64; c++) begin
            cycle();
            if (s_valid) begin
                if (k == 0) begin
                    tests_run++; if (c - 1 != 5) begin tests_failed++; $display("FAIL clean_first_latency: got %0d expected 5", c - 1); end
                end else begin
                    tests_run++; if (c - t_last != CD) begin tests_failed++; $display("FAIL clean_interval[%0d]: got %0d expected %0d", k, c - t_last, CD); end
                end
                t_last = c;
                e = ((k % NS) < NS / 2) ? DW'(1000) : DW'(-1000);
                tests_run++; if (s_dbits !== e) begin tests_failed++; $display("FAIL clean_data[%0d]: got %0d expected %0d", k, $signed(s_dbits), $signed(e)); end
                tests_run++; if (s_pstart !== ((k % NS) == 0)) begin tests_failed++; $display("FAIL clean_pstart[%0d]: got %0b expected %0b", k, s_pstart, (k % NS) == 0); end
                if (k == NS - 1) begin
                    tests_run++; if (s_frame !== 16'd1) begin tests_failed++; $display("FAIL clean_frame1: got %0d expected 1", s_frame); end
                end
                k++;
                if (k == 63) i_Enable = 1'b0;
            end
        end
        tests_run++; if (k != 64) begin tests_failed++; $display("FAIL clean_strobes: got %0d expected 64", k); end
        for (int i = 0; i < 12; i++) begin cycle(); if (s_valid) extra++; end
        tests_run++; if (extra != 0) begin tests_failed++; $display("FAIL clean_extra: got %0d expected 0", extra); end
        tests_run++; if (s_frame !== 16'd2) begin tests_failed++; $display("FAIL clean_frame2: got %0d expected 2", s_frame); end
        tests_run++; if (s_busy !== 1'b0 || s_state !== 2'd0) begin tests_failed++; $display("FAIL clean_idle: got busy=%0b state=%0d expected 0/0", s_busy, s_state); end
    endtask

    task automatic test_noise_path();
        int k = 0, lf0, st0, idle_pulses = 0;
        logic [DW-1:0] e;
        i_Amplitude = '0; i_LFSR_Data = 12'hFF0; i_Noise_Shift = 4'd2; gen_on = 1'b0;
        lf0 = lfsr_cnt; st0 = strobe_cnt;
        i_Enable = 1'b1;
        for (int c = 0; c < 300 && k < NS; c++) begin
            cycle();
            if (s_valid) begin
                e = (k < 4) ? DW'(-4) : '0;
                tests_run++; if (s_dbits !== e) begin tests_failed++; $display("FAIL noise_data[%0d]: got %0d expected %0d", k, $signed(s_dbits), $signed(e)); end
                k++;
                if (k == 4) i_Noise_Shift = 4'd12;
                if (k == 8) i_Enable = 1'b0;
            end
        end
        repeat (8) cycle();
        tests_run++; if (strobe_cnt - st0 != NS) begin tests_failed++; $display("FAIL noise_strobes: got %0d expected %0d", strobe_cnt - st0, NS); end
        tests_run++; if (lfsr_cnt - lf0 != strobe_cnt - st0) begin tests_failed++; $display("FAIL noise_lfsr_per_strobe: got %0d expected %0d", lfsr_cnt - lf0, strobe_cnt - st0); end
        lf0 = lfsr_cnt;
        repeat (12) cycle();
        idle_pulses = lfsr_cnt - lf0;
        tests_run++; if (idle_pulses != 0) begin tests_failed++; $display("FAIL noise_idle_lfsr: got %0d expected 0", idle_pulses); end
    endtask

    task automatic test_overflow();
        int k = 0;
        logic [DW-1:0] e, pos;
`ifdef NOISY_SIG_SATURATE_EN
        pos = DW'(8191);
`else
        pos = DW'(-6337);
`endif
        i_Amplitude = DW'(8000); i_LFSR_Data = 12'h7FF; i_Noise_Shift = 4'd0; gen_on = 1'b0;
        i_Enable = 1'b1;
        for (int c = 0; c < 300 && k < NS; c++) begin
            cycle();
            if (s_valid) begin
                e = (k < NS / 2) ? pos : DW'(-5953);
                tests_run++; if (s_dbits !== e) begin tests_failed++; $display("FAIL overflow_data[%0d]: got %0d expected %0d", k, $signed(s_dbits), $signed(e)); end
                k++;
                i_Enable = 1'b0;
            end
        end
        tests_run++; if (k != NS) begin tests_failed++; $display("FAIL overflow_strobes: got %0d expected %0d", k, NS); end
        repeat (8) cycle();
    endtask

    task automatic test_period_stop();
        int k = 0, lf0, lf_last = 0;
        logic [DW-1:0] e;
        randomize_inputs(); i_LFSR_Data = NB'($urandom); gen_on = 1'b1;
        exp_q.delete(); push_exp(0);
        lf0 = lfsr_cnt;
        i_Enable = 1'b1;
        for (int c = 0; c < 200; c++) begin
            cycle();
            if (k == NS && c > 0 && lf_last == 0) begin
                lf_last = 1;
                tests_run++; if (s_busy !== 1'b0) begin tests_failed++; $display("FAIL stop_busy_after: got %0b expected 0", s_busy); end
            end
            if (s_valid) begin
                e = exp_q.pop_front();
                tests_run++; if (s_dbits !== e) begin tests_failed++; $display("FAIL stop_data[%0d]: got %0d expected %0d", k, $signed(s_dbits), $signed(e)); end
                if (k == NS - 2) begin
                    tests_run++; if (s_busy !== 1'b1) begin tests_failed++; $display("FAIL stop_busy_during: got %0b expected 1", s_busy); end
                end
                k++;
                if (k == 6) i_Enable = 1'b0;
                randomize_inputs();
                push_exp(k % NS);
            end
        end
        tests_run++; if (k != 6 + 26) begin tests_failed++; $display("FAIL stop_strobes: got %0d expected 32", k); end
        tests_run++; if (s_frame !== 16'd1) begin tests_failed++; $display("FAIL stop_frame: got %0d expected 1", s_frame); end
        tests_run++; if (lfsr_cnt - lf0 != NS) begin tests_failed++; $display("FAIL stop_lfsr_total: got %0d expected %0d", lfsr_cnt - lf0, NS); end
    endtask

    task automatic test_reset_mid_run();
        int k = 0, st0, lf0, c;
        logic [DW-1:0] e;
        bit seen = 1'b0;
        randomize_inputs(); i_LFSR_Data = NB'($urandom); gen_on = 1'b1;
        exp_q.delete(); push_exp(0);
        i_Enable = 1'b1;
        for (c = 0; c < 200 && k < 10; c++) begin
            cycle();
            if (s_valid) begin
                e = exp_q.pop_front();
                tests_run++; if (s_dbits !== e) begin tests_failed++; $display("FAIL rst_run_data[%0d]: got %0d expected %0d", k, $signed(s_dbits), $signed(e)); end
                k++;
                randomize_inputs();
                push_exp(k % NS);
            end
        end
        tests_run++; if (k != 10) begin tests_failed++; $display("FAIL rst_pre_strobes: got %0d expected 10", k); end
        i_Reset = 1'b1;
        cycle();
        i_Reset = 1'b0; i_Enable = 1'b0;
        cycle();
        tests_run++; if (s_valid !== 1'b0 || s_pstart !== 1'b0 || s_lfsr !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_strobes: got v=%0b p=%0b l=%0b expected 0/0/0", s_valid, s_pstart, s_lfsr); end
        tests_run++; if (s_dbits !== '0 || s_frame !== 16'd0) begin tests_failed++; $display("FAIL rst_mid_regs: got data=%0d frame=%0d expected 0/0", $signed(s_dbits), s_frame); end
        tests_run++; if (s_busy !== 1'b0 || s_state !== 2'd0) begin tests_failed++; $display("FAIL rst_mid_state: got busy=%0b state=%0d expected 0/0", s_busy, s_state); end
        st0 = strobe_cnt; lf0 = lfsr_cnt;
        repeat (8) cycle();
        tests_run++; if (strobe_cnt != st0 || lfsr_cnt != lf0) begin tests_failed++; $display("FAIL rst_mid_quiet: got %0d strobes %0d pulses expected 0/0", strobe_cnt - st0, lfsr_cnt - lf0); end
        // Restart: index 0 first, period start flagged, normal latency.
        k = 0;
        exp_q.delete(); push_exp(0);
        i_Enable = 1'b1;
        for (c = 1; c <= 300 && (!seen || s_busy); c++) begin
            cycle();
            if (s_valid) begin
                e = exp_q.pop_front();
                if (k == 0) begin
                    seen = 1'b1;
                    tests_run++; if (c - 1 != 5) begin tests_failed++; $display("FAIL rst_restart_latency: got %0d expected 5", c - 1); end
                    tests_run++; if (s_pstart !== 1'b1) begin tests_failed++; $display("FAIL rst_restart_pstart: got %0b expected 1", s_pstart); end
                    tests_run++; if (s_frame !== 16'd0) begin tests_failed++; $display("FAIL rst_restart_frame: got %0d expected 0", s_frame); end
                    i_Enable = 1'b0;
                end
                tests_run++; if (s_dbits !== e) begin tests_failed++; $display("FAIL rst_restart_data[%0d]: got %0d expected %0d", k, $signed(s_dbits), $signed(e)); end
                k++;
                randomize_inputs();
                push_exp(k % NS);
            end
        end
        tests_run++; if (k != NS) begin tests_failed++; $display("FAIL rst_restart_strobes: got %0d expected %0d", k, NS); end
    endtask

    task automatic test_amp_clamp();
        int k = 0;
        logic [DW-1:0] e;
        i_Amplitude = 14'h3FFF; i_LFSR_Data = '0; i_Noise_Shift = 4'd0; gen_on = 1'b0;
        i_Enable = 1'b1;
        for (int c = 0; c < 300 && k < NS; c++) begin
            cycle();
            if (s_valid) begin
                e = (k < NS / 2) ? DW'(8191) : DW'(-8191);
                tests_run++; if (s_dbits !== e) begin tests_failed++; $display("FAIL clamp_data[%0d]: got %0d expected %0d", k, $signed(s_dbits), $signed(e)); end
                k++;
                i_Enable = 1'b0;
            end
        end
        tests_run++; if (k != NS) begin tests_failed++; $display("FAIL clamp_strobes: got %0d expected %0d", k, NS); end
        repeat (8) cycle();
    endtask

    task automatic test_random();
        int k, m, total, st0, lf0;
        logic [DW-1:0] e;
        for (int s = 0; s < 4; s++) begin
            m = $urandom_range(1, 60);
            if (m % NS == 0) m = m + 1;
            total = (m < NS) ? NS : 2 * NS;
            randomize_inputs(); i_LFSR_Data = NB'($urandom); gen_on = 1'b1;
            exp_q.delete(); push_exp(0);
            st0 = strobe_cnt; lf0 = lfsr_cnt; k = 0;
            i_Enable = 1'b1;
            for (int c = 0; c < 600 && k < total; c++) begin
                cycle();
                if (s_valid) begin
                    e = exp_q.pop_front();
                    tests_run++; if (s_dbits !== e) begin tests_failed++; $display("FAIL rand_data[s%0d k%0d]: got %0d expected %0d", s, k, $signed(s_dbits), $signed(e)); end
                    tests_run++; if (s_pstart !== ((k % NS) == 0)) begin tests_failed++; $display("FAIL rand_pstart[s%0d k%0d]: got %0b expected %0b", s, k, s_pstart, (k % NS) == 0); end
                    k++;
                    if (k == m) i_Enable = 1'b0;
                    randomize_inputs();
                    push_exp(k % NS);
                end
            end
            repeat (8) cycle();
            tests_run++; if (strobe_cnt - st0 != total) begin tests_failed++; $display("FAIL rand_strobes[s%0d]: got %0d expected %0d", s, strobe_cnt - st0, total); end
            tests_run++; if (lfsr_cnt - lf0 != total) begin tests_failed++; $display("FAIL rand_lfsr[s%0d]: got %0d expected %0d", s, lfsr_cnt - lf0, total); end
            tests_run++; if (s_frame !== 16'(total / NS)) begin tests_failed++; $display("FAIL rand_frame[s%0d]: got %0d expected %0d", s, s_frame, total / NS); end
            tests_run++; if (s_busy !== 1'b0) begin tests_failed++; $display("FAIL rand_busy[s%0d]: got %0b expected 0", s, s_busy); end
            repeat ($urandom_range(1, 6)) cycle();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        i_Reset       = 1'b1;
        i_Enable      = 1'b0;
        i_Amplitude   = '0;
        i_Noise_Shift = 4'd0;
        i_LFSR_Data   = '0;
        test_reset();
        test_clean_wave();
        test_noise_path();
        test_overflow();
        test_period_stop();
        test_reset_mid_run();
        test_amp_clamp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/noisy_signal_gen.md
Name: noisy_signal_gen

Overview:
Synthetic test-signal source for the coherent-average / lock-in bench.
- Emits a periodic square wave of programmable amplitude, N_SAMPLES samples per period, one sample every CLK_DIV clocks.
- Adds pseudo-random noise taken from a pseudo-random word generator, and drives that generator's enable so it advances exactly once per emitted sample.
- Output feeds the coherent averager as its ADC-like sample stream.

Parameters:
DATA_WIDTH, 14, width of signed output sample.
NOISE_BITS, 12, width of noise word from the noise generator, treated as signed.
N_SAMPLES, 32, samples per period; even, >= 2.
CLK_DIV, 4, clocks per sample; >= 2.

Ports:
i_Clk  input  1  clock.
i_Reset  input  1  synchronous, active-high reset.
i_Enable  input  1  level run request.
i_Amplitude  input  DATA_WIDTH  unsigned square-wave amplitude.
i_Noise_Shift  input  4  arithmetic right shift applied to the noise word.
i_LFSR_Data  input  NOISE_BITS  current noise word from the generator.
o_LFSR_Enable  output  1  advance pulse to the generator.
o_Data  output  DATA_WIDTH  signed sample.
o_Data_Valid  output  1  one-cycle strobe for o_Data.
o_Period_Start  output  1  high with o_Data_Valid on sample index 0.
o_Frame_Count  output  16  completed periods since the last start.
o_Busy  output  1  high in RUN and DRAIN.

Behaviour:
- Reset: the synchronous reset (i_Reset, active high) has priority over everything. It forces state IDLE, clears the divider and sample index to 0, and zeroes o_Data, o_Data_Valid, o_Period_Start, o_LFSR_Enable, o_Frame_Count and o_Busy. Reset mid-period abandons the period; no further strobes follow.
- States and transitions:
  - IDLE -> RUN when i_Enable=1. On that transition o_Frame_Count clears to 0, divider=0, index=0.
  - RUN -> DRAIN when i_Enable=0 and index != 0 at a tick.
  - RUN -> IDLE directly if i_Enable=0 when the next sample would be index 0.
  - DRAIN ignores i_Enable. It emits the remaining samples of the current period, then goes to IDLE. Stops are therefore always period-aligned.
- Divider: counts 0..CLK_DIV-1 in RUN/DRAIN. The "tick" cycle is divider==CLK_DIV-1.
  - The first tick occurs CLK_DIV cycles after entering RUN.
- Tick cycle: o_LFSR_Enable=1 for exactly that cycle; it is registered, so it aligns with the tick. i_LFSR_Data is sampled in the same cycle, so the generator advances after use.
- Latency: o_Data and o_Data_Valid are registered and appear on the cycle after the tick. o_Data holds its value between strobes. o_Data_Valid is otherwise 0.
- Waveform: sig = +A for index < N_SAMPLES/2, else -A.
  - A = min(i_Amplitude, 2^(DATA_WIDTH-1)-1).
- Noise: i_LFSR_Data is interpreted as two's complement, then arithmetically right-shifted by i_Noise_Shift.
  - If i_Noise_Shift >= NOISE_BITS, noise = 0.
- Sum: computed in DATA_WIDTH+2 bits, then reduced to DATA_WIDTH per the optional feature.
- Index: increments per tick and wraps N_SAMPLES-1 -> 0. o_Period_Start is asserted with the index-0 strobe.
- Frame count: o_Frame_Count increments with the index N_SAMPLES-1 strobe and saturates at 16'hFFFF.
- Input changes: i_Amplitude and i_Noise_Shift changes take effect at the next tick. No per-period latching.

Optional Feature:
NOISY_SIG_SATURATE_EN
- Defined: the sum is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Undefined: the sum is truncated to its low DATA_WIDTH bits (two's-complement wrap).

Test Plan:
All scenarios use default parameters.
1. Clean waveform: A=1000, i_LFSR_Data=0, shift=0, enable held.
   -> Valid strobes every 4 clocks; the first strobe comes 5 clocks after enable.
   -> Values: 16x +1000 then 16x -1000, repeating.
   -> o_Period_Start on every 32nd strobe; o_Frame_Count = 1 after the 32nd strobe.
2. Noise path: A=0, i_LFSR_Data=12'hFF0 (-16).
   -> shift=2 gives o_Data=-4; shift=12 gives o_Data=0.
   -> Exactly one o_LFSR_Enable pulse per strobe, with no pulses in IDLE.
3. Overflow: A=8000, i_LFSR_Data=12'h7FF, shift=0.
   -> Positive half: 8191 with the macro defined; -6337 without it.
4. Period-aligned stop: drop i_Enable after the 6th strobe.
   -> 26 further strobes are emitted; o_Busy falls after the last one.
   -> o_Frame_Count = 1; no o_LFSR_Enable afterwards.
5. Reset mid-run: assert i_Reset at sample 10.
   -> The next cycle shows all outputs 0 and state IDLE.
   -> Re-enabling restarts at index 0 with o_Period_Start on the first strobe.
6. Amplitude clamp: i_Amplitude=14'h3FFF, noise 0 -> o_Data = +8191 / -8191.
